sc_frame_receiver: RTL and testbench
====================================

// Module: sc_frame_receiver
// PURPOSE
//  Receiving end of the MAROC slow-control serial link (D_SC / CK_SC / RSTn_SC).
//  Deserialises one FRAME_LEN-bit frame, LSB first, back into a parallel word
//  and checks framing. It is used for loop-back self-test of the transmitter
//  and for capturing the chip's shifted-out slow-control chain.
//  CK_SC and RSTn_SC are asynchronous to CK_in. They are resynchronised and
//  sampled in the CK_in domain.
// PARAMETERS
//  FRAME_LEN  829    bits per slow-control frame
//  SYNC_STG   2      synchroniser flops on D_SC, CK_SC and RSTn_SC
//  TIMEOUT    4096   CK_in cycles allowed without a CK_SC fall during SHIFT
// PORTS
//  CK_in        in   1          system clock
//  rstn         in   1          synchronous reset, active low
//  D_SC         in   1          serial slow-control data
//  CK_SC        in   1          serial slow-control clock; data is sampled on its falling edge
//  RSTn_SC      in   1          link reset, active low; aborts the frame in progress
//  frame_data   out  FRAME_LEN  last complete frame; bit 0 = first bit received
//  frame_valid  out  1          1-cycle pulse when frame_data is updated
//  frame_err    out  1          1-cycle pulse on timeout or overflow
//  overflow     out  1          sticky: CK_SC edge seen after a complete frame
//  busy         out  1          1 while in SHIFT
//  bit_cnt      out  10         bits received in the current frame (0..FRAME_LEN)
//  dac1         out  10         frame_data[22:13], updated together with frame_data
//  dac2         out  10         frame_data[12:3], updated together with frame_data
// BEHAVIOUR
//  Reset (rstn=0 at a CK_in rise):
//   - every output is 0 and the state is IDLE
//   - the shift register, counters and synchroniser flops are cleared
//   - rstn overrides every other event
//  Synchronisation and edge detection:
//   - D_SC, CK_SC and RSTn_SC each pass through SYNC_STG flops, then one more
//     registered stage for edge detection
//   - fall = ck_d & ~ck_s; D_SC is delayed identically, so the sampled bit is
//     aligned with fall
//   - constraint: each CK_SC half-period is at least SYNC_STG+2 CK_in cycles;
//     faster clocks are out of spec and unchecked
//  Shift register:
//   - on fall: sreg <= {d_s, sreg[FRAME_LEN-1:1]} and bit_cnt increments
//   - after FRAME_LEN falls, sreg[0] holds the first bit received
//  FSM states: IDLE, SHIFT, DONE, OVF
//   - IDLE: bit_cnt=0. On fall: shift the bit in, bit_cnt=1, go to SHIFT.
//   - SHIFT: on each fall, shift and increment. The fall that makes
//     bit_cnt==FRAME_LEN goes to DONE.
//   - SHIFT timeout: the idle counter is cleared on every fall. If it reaches
//     TIMEOUT-1, pulse frame_err, clear bit_cnt, go to IDLE. frame_data is unchanged.
//   - DONE (one cycle): frame_data <= sreg, frame_valid=1, dac1/dac2 update.
//     bit_cnt stays at FRAME_LEN. Then go to OVF-watch (state OVF with overflow=0).
//   - OVF: on a fall, set overflow=1 and pulse frame_err once. Further falls
//     are ignored. frame_data is held.
//  RSTn_SC (synchronised, level low):
//   - from any state except reset: bit_cnt=0, go to IDLE, overflow cleared
//   - no frame_valid and no frame_err are generated
//   - if low in the same cycle as a fall, the fall is discarded
//  Latency: frame_valid rises exactly SYNC_STG+2 CK_in cycles after the first
//   CK_in rise that samples the final CK_SC low.
//  Simultaneous events:
//   - a timeout in the same cycle as a fall: the fall wins and the counter clears
//   - frame_valid and frame_err are never high in the same cycle
//  Back-to-back frames need a RSTn_SC pulse between them (transmitter protocol);
//   without one, the extra bits raise overflow.
// TESTING
//  1 Reset: rstn=0 for 3 cycles with random inputs -> all outputs 0 and state IDLE.
//  2 Loop-back: instantiate transmitter, fixed seed, 3 frames, RSTn_SC between them
//    -> frame_data equals the packed inputs each time; one frame_valid per frame;
//    dac1 = DAC1 and dac2 = DAC2.
//  3 Pattern frame: bit0=1, bit828=1, all others 0 -> frame_data[0]=1,
//    frame_data[828]=1, popcount 2, frame_valid asserted SYNC_STG+2 cycles after the last fall.
//  4 Abort: RSTn_SC low after 400 bits, then a full frame of all ones -> no pulse
//    at the abort; frame_data = all ones; bit_cnt=829.
//  5 Timeout: 100 bits, then CK_SC held for TIMEOUT cycles -> one frame_err pulse,
//    bit_cnt=0, frame_data unchanged.
//  6 Overflow: 830 falls with no RSTn_SC -> frame_valid after fall 829; after
//    fall 830, overflow=1 and one frame_err pulse; RSTn_SC low clears overflow.

Source files
------------

// File: rtl/sc_frame_receiver.sv
// Slow-control serial link receiver: resynchronises D_SC/CK_SC/RSTn_SC into CK_in,
// shifts one frame in LSB first on CK_SC falls, and reports valid/timeout/overflow.
module sc_frame_receiver #(
    parameter int FRAME_LEN = 829,
    parameter int SYNC_STG  = 2,
    parameter int TIMEOUT   = 4096
) (
    input  logic                 CK_in,
    input  logic                 rstn,
    input  logic                 D_SC,
    input  logic                 CK_SC,
    input  logic                 RSTn_SC,
    output logic [FRAME_LEN-1:0] frame_data,
    output logic                 frame_valid,
    output logic                 frame_err,
    output logic                 overflow,
    output logic                 busy,
    output logic [9:0]           bit_cnt,
    output logic [9:0]           dac1,
    output logic [9:0]           dac2
);

    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2,
        OVF   = 2'd3
    } state_t;

    state_t                state_r, state_next_s;
    logic [SYNC_STG-1:0]   d_sync_r, ck_sync_r, rsc_sync_r;
    logic                  d_s_r, ck_s_r, ck_d_r, rsc_s_r;
    logic                  fall_s;
    logic [FRAME_LEN-1:0]  sreg_r, sreg_next_s;
    logic [FRAME_LEN-1:0]  frame_data_r, frame_data_next_s;
    logic [TW-1:0]         idle_r, idle_next_s;
    logic [9:0]            bit_cnt_r, bit_cnt_next_s;
    logic [9:0]            dac1_r, dac1_next_s, dac2_r, dac2_next_s;
    logic                  valid_r, valid_next_s;
    logic                  err_r, err_next_s;
    logic                  ovf_r, ovf_next_s;
    logic                  busy_r;

    // The extra stage after the synchroniser gives ck_s/d_s the same latency, so d_s is aligned with fall
    assign fall_s = ck_d_r & ~ck_s_r;

    // Synchronisers, edge-detect stage, FSM state and registered outputs
    always_ff @(posedge CK_in) begin
        if (!rstn) begin
            d_sync_r     <= '0;
            ck_sync_r    <= '0;
            rsc_sync_r   <= '0;
            d_s_r        <= 1'b0;
            ck_s_r       <= 1'b0;
            ck_d_r       <= 1'b0;
            rsc_s_r      <= 1'b0;
            state_r      <= IDLE;
            sreg_r       <= '0;
            frame_data_r <= '0;
            idle_r       <= '0;
            bit_cnt_r    <= 10'd0;
            dac1_r       <= 10'd0;
            dac2_r       <= 10'd0;
            valid_r      <= 1'b0;
            err_r        <= 1'b0;
            ovf_r        <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            d_sync_r     <= {d_sync_r[SYNC_STG-2:0], D_SC};
            ck_sync_r    <= {ck_sync_r[SYNC_STG-2:0], CK_SC};
            rsc_sync_r   <= {rsc_sync_r[SYNC_STG-2:0], RSTn_SC};
            d_s_r        <= d_sync_r[SYNC_STG-1];
            ck_s_r       <= ck_sync_r[SYNC_STG-1];
            rsc_s_r      <= rsc_sync_r[SYNC_STG-1];
            ck_d_r       <= ck_s_r;
            state_r      <= state_next_s;
            sreg_r       <= sreg_next_s;
            frame_data_r <= frame_data_next_s;
            idle_r       <= idle_next_s;
            bit_cnt_r    <= bit_cnt_next_s;
            dac1_r       <= dac1_next_s;
            dac2_r       <= dac2_next_s;
            valid_r      <= valid_next_s;
            err_r        <= err_next_s;
            ovf_r        <= ovf_next_s;
            busy_r       <= (state_next_s == SHIFT);
        end
    end

    // Next-state and next-output logic; a low link reset discards any coincident fall
    always_comb begin
        state_next_s      = state_r;
        sreg_next_s       = sreg_r;
        frame_data_next_s = frame_data_r;
        idle_next_s       = idle_r;
        bit_cnt_next_s    = bit_cnt_r;
        dac1_next_s       = dac1_r;
        dac2_next_s       = dac2_r;
        valid_next_s      = 1'b0;
        err_next_s        = 1'b0;
        ovf_next_s        = ovf_r;
        if (!rsc_s_r) begin
            state_next_s   = IDLE;
            bit_cnt_next_s = 10'd0;
            idle_next_s    = '0;
            ovf_next_s     = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    idle_next_s = '0;
                    if (fall_s) begin
                        sreg_next_s    = {d_s_r, sreg_r[FRAME_LEN-1:1]};
                        bit_cnt_next_s = 10'd1;
                        state_next_s   = SHIFT;
                    end else begin
                        bit_cnt_next_s = 10'd0;
                    end
                end
                SHIFT: begin
                    if (fall_s) begin
                        sreg_next_s    = {d_s_r, sreg_r[FRAME_LEN-1:1]};
                        bit_cnt_next_s = bit_cnt_r + 10'd1;
                        idle_next_s    = '0;
                        if (bit_cnt_r == 10'(FRAME_LEN - 1)) begin
                            state_next_s = DONE;
                        end else begin
                            state_next_s = SHIFT;
                        end
                    end else if (idle_r == TW'(TIMEOUT - 1)) begin
                        err_next_s     = 1'b1;
                        bit_cnt_next_s = 10'd0;
                        idle_next_s    = '0;
                        state_next_s   = IDLE;
                    end else begin
                        idle_next_s = idle_r + TW'(1);
                    end
                end
                DONE: begin
                    frame_data_next_s = sreg_r;
                    dac1_next_s       = sreg_r[22:13];
                    dac2_next_s       = sreg_r[12:3];
                    valid_next_s      = 1'b1;
                    ovf_next_s        = 1'b0;
                    state_next_s      = OVF;
                end
                OVF: begin
                    if (fall_s && !ovf_r) begin
                        ovf_next_s = 1'b1;
                        err_next_s = 1'b1;
                    end else begin
                        ovf_next_s = ovf_r;
                    end
                end
                default: begin
                    state_next_s   = IDLE;
                    bit_cnt_next_s = 10'd0;
                end
            endcase
        end
    end

    assign frame_data  = frame_data_r;
    assign frame_valid = valid_r;
    assign frame_err   = err_r;
    assign overflow    = ovf_r;
    assign busy        = busy_r;
    assign bit_cnt     = bit_cnt_r;
    assign dac1        = dac1_r;
    assign dac2        = dac2_r;

endmodule

// File: tb/tb_sc_frame_receiver.sv
// Directed self-checking bench for sc_frame_receiver: reset, loop-back frames,
// latency, abort, timeout and overflow.
module tb_sc_frame_receiver;

    localparam int FL = 829;
    localparam int HP = 5;

    logic          clk = 1'b0;
    logic          rstn, d_sc, ck_sc, rstn_sc;
    logic [FL-1:0] frame_data;
    logic          frame_valid, frame_err, overflow, busy;
    logic [9:0]    bit_cnt, dac1, dac2;

    int checks_cnt = 0;
    int errors_cnt = 0;
    int fv_cnt = 0;
    int fe_cnt = 0;
    int both_cnt = 0;

    sc_frame_receiver #(.FRAME_LEN(FL), .SYNC_STG(2), .TIMEOUT(4096)) dut (
        .CK_in(clk), .rstn(rstn), .D_SC(d_sc), .CK_SC(ck_sc), .RSTn_SC(rstn_sc),
        .frame_data(frame_data), .frame_valid(frame_valid), .frame_err(frame_err),
        .overflow(overflow), .busy(busy), .bit_cnt(bit_cnt), .dac1(dac1), .dac2(dac2)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled just after each rising edge
    always @(posedge clk) begin
        #1;
        if (rstn) begin
            if (frame_valid) fv_cnt++;
            if (frame_err) fe_cnt++;
            if (frame_valid && frame_err) both_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [FL-1:0] obs, input logic [FL-1:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        d_sc  = b;
        ck_sc = 1'b1;
        repeat (HP) @(negedge clk);
        ck_sc = 1'b0;
        repeat (HP) @(negedge clk);
    endtask

    task automatic send_frame(input logic [FL-1:0] v, input int n);
        for (int i = 0; i < n; i++) send_bit(v[i]);
        repeat (4) @(negedge clk);
    endtask

    task automatic link_reset();
        rstn_sc = 1'b0;
        repeat (8) @(negedge clk);
        rstn_sc = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    logic [FL-1:0] data, ones, patt;
    int fv0, fe0, lat, cyc;

    initial begin
        rstn = 1'b0; d_sc = 1'b0; ck_sc = 1'b0; rstn_sc = 1'b1;
        ones = '1;
        // 1: reset with random inputs
        repeat (3) begin
            @(negedge clk);
            d_sc = 1'($urandom); ck_sc = 1'($urandom); rstn_sc = 1'($urandom);
        end
        @(negedge clk);
        chk("rst_data", frame_data, '0);
        chk("rst_flags", {frame_valid, frame_err, overflow, busy}, 4'd0);
        chk("rst_cnt", {bit_cnt, dac1, dac2}, 30'd0);
        rstn = 1'b1; d_sc = 1'b0; ck_sc = 1'b0; rstn_sc = 1'b1;
        repeat (10) @(negedge clk);

        // 2: loop-back of three frames
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < FL; i++) data[i] = 1'($urandom);
            fv0 = fv_cnt;
            send_frame(data, FL);
            chk("lb_data", frame_data, data);
            chk("lb_dac1", dac1, data[22:13]);
            chk("lb_dac2", dac2, data[12:3]);
            chk("lb_nvalid", fv_cnt - fv0, 1);
            chk("lb_cnt", bit_cnt, 10'd829);
            link_reset();
        end

        // 3: two-bit pattern and output latency
        data = '0; data[0] = 1'b1; data[FL-1] = 1'b1;
        for (int i = 0; i < FL - 1; i++) send_bit(data[i]);
        d_sc = 1'b1; ck_sc = 1'b1;
        repeat (HP) @(negedge clk);
        ck_sc = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (frame_valid && lat == 0) lat = k;
        end
        chk("pat_latency", lat, 5);
        chk("pat_bit0", frame_data[0], 1'b1);
        chk("pat_bit828", frame_data[FL-1], 1'b1);
        chk("pat_popcount", $countones(frame_data), 2);
        link_reset();

        // 4: abort after 400 bits, then an all-ones frame
        fv0 = fv_cnt; fe0 = fe_cnt;
        send_frame(ones, 400);
        chk("abort_partial_cnt", bit_cnt, 10'd400);
        chk("abort_busy", busy, 1'b1);
        link_reset();
        chk("abort_cnt_clr", bit_cnt, 10'd0);
        chk("abort_no_pulse", {fv_cnt - fv0, fe_cnt - fe0}, 64'd0);
        send_frame(ones, FL);
        chk("abort_data", frame_data, ones);
        chk("abort_cnt", bit_cnt, 10'd829);
        link_reset();

        // 5: timeout after 100 bits
        fv0 = fv_cnt; fe0 = fe_cnt;
        send_frame('0, 100);
        chk("to_cnt", bit_cnt, 10'd100);
        cyc = 0;
        while (fe_cnt == fe0 && cyc < 4400) begin
            @(negedge clk);
            cyc++;
        end
        repeat (20) @(negedge clk);
        chk("to_window", (cyc >= 4000) && (cyc <= 4200), 1'b1);
        chk("to_nerr", fe_cnt - fe0, 1);
        chk("to_nvalid", fv_cnt - fv0, 0);
        chk("to_cnt_clr", bit_cnt, 10'd0);
        chk("to_busy", busy, 1'b0);
        chk("to_data_held", frame_data, ones);
        link_reset();

        // 6: overflow with no link reset after the frame
        for (int i = 0; i < FL; i++) patt[i] = 1'(i % 3 == 0);
        fv0 = fv_cnt; fe0 = fe_cnt;
        send_frame(patt, FL);
        chk("ovf_nvalid", fv_cnt - fv0, 1);
        chk("ovf_pre", overflow, 1'b0);
        chk("ovf_data", frame_data, patt);
        send_bit(1'b1);
        repeat (4) @(negedge clk);
        chk("ovf_set", overflow, 1'b1);
        chk("ovf_nerr", fe_cnt - fe0, 1);
        send_bit(1'b0);
        repeat (4) @(negedge clk);
        chk("ovf_nerr_once", fe_cnt - fe0, 1);
        chk("ovf_data_held", frame_data, patt);
        chk("ovf_cnt_hold", bit_cnt, 10'd829);
        link_reset();
        chk("ovf_clr", overflow, 1'b0);
        chk("ovf_cnt_clr", bit_cnt, 10'd0);
        chk("valid_err_overlap", both_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
